display_source_select: RTL and testbench

DISPLAY_SOURCE_SELECT -- requirements
Module: display_source_select

---
 rtl/display_source_select.sv | 154 +++++++++++++++
 tb/tb_display_source_select.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_source_select.sv
// Selects one of four 32-bit debug values for a four-digit display, with
// debounced next/freeze buttons and periodic resampling of the selected source.

module display_source_select_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic press_o
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // High for the single cycle after the debounced level rises.
  assign press_o = level_q & ~prev_q;
endmodule

module display_source_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SAMPLE_PERIOD   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_freeze,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  output logic [12:0] Num,
  output logic [1:0]  sel,
  output logic        frozen,
  output logic        ovf
);
  localparam int SW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic          next_press;
  logic          freeze_press;
  logic [SW-1:0] samp_q;
  logic [SW-1:0] samp_d;
  logic          tick;
  logic [1:0]    sel_q;
  logic [1:0]    sel_d;
  logic          frozen_q;
  logic          frozen_d;
  logic [12:0]   num_q;
  logic [12:0]   num_d;
  logic          ovf_q;
  logic          ovf_d;
  logic [31:0]   src_sel;
  logic          src_big;
  logic          load;

  display_source_select_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk       (clk),
    .rst       (rst),
    .btn_raw_i (btn_next),
    .press_o   (next_press)
  );

  display_source_select_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_freeze (
    .clk       (clk),
    .rst       (rst),
    .btn_raw_i (btn_freeze),
    .press_o   (freeze_press)
  );

  assign tick   = (samp_q == SW'(SAMPLE_PERIOD - 1));
  assign samp_d = tick ? '0 : samp_q + SW'(1);

  assign sel_d    = sel_q + {1'b0, next_press};
  assign frozen_d = frozen_q ^ freeze_press;

  // Mux on the post-update select so a press loads the new source immediately.
  always_comb begin
    src_sel = src0;
    case (sel_d)
      2'd0: src_sel = src0;
      2'd1: src_sel = src1;
      2'd2: src_sel = src2;
      2'd3: src_sel = src3;
      default: src_sel = src0;
    endcase
  end

  assign src_big = |src_sel[31:13];
  assign load    = tick | (sel_d != sel_q) | (frozen_q & ~frozen_d);

  always_comb begin
    num_d = num_q;
    ovf_d = ovf_q;
    if (load && !frozen_d) begin
      num_d = src_big ? 13'h1FFF : src_sel[12:0];
      ovf_d = src_big;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q   <= '0;
      sel_q    <= 2'd0;
      frozen_q <= 1'b0;
      num_q    <= 13'd0;
      ovf_q    <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      sel_q    <= sel_d;
      frozen_q <= frozen_d;
      num_q    <= num_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Num    = num_q;
  assign sel    = sel_q;
  assign frozen = frozen_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_display_source_select.sv
// Bench for display_source_select: directed table, hand sequences for freeze and
// reset corners, and randomized buttons/sources against a cycle reference model.

module tb_display_source_select;
  localparam int DEB = 4;
  localparam int PER = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_next;
  logic        btn_freeze;
  logic [31:0] src0, src1, src2, src3;
  logic [12:0] Num;
  logic [1:0]  sel;
  logic        frozen;
  logic        ovf;

  always #5 clk = ~clk;

  display_source_select #(.DEBOUNCE_CYCLES(DEB), .SAMPLE_PERIOD(PER)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_next   (btn_next),
    .btn_freeze (btn_freeze),
    .src0       (src0),
    .src1       (src1),
    .src2       (src2),
    .src3       (src3),
    .Num        (Num),
    .sel        (sel),
    .frozen     (frozen),
    .ovf        (ovf)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: raw level seen two cycles late, accepted after a streak of
  // DEB differing cycles, a press is the cycle after acceptance of a high level.
  bit          m_s1[2], m_s2[2], m_db[2], m_dbp[2];
  int          m_run[2];
  int          m_samp, m_sel, m_num;
  bit          m_fr, m_ovf;

  function automatic longint unsigned src_of(input int i);
    case (i)
      0: return src0;
      1: return src1;
      2: return src2;
      default: return src3;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit raw[2];
    bit pulse[2];
    bit tick, nf, load;
    int ns;
    longint unsigned v;
    raw[0] = btn_next;
    raw[1] = btn_freeze;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbp[i] = 0; m_run[i] = 0;
      end
      m_samp = 0; m_sel = 0; m_num = 0; m_fr = 0; m_ovf = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pulse[i] = m_db[i] && !m_dbp[i];
        m_dbp[i] = m_db[i];
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_db[i]  = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
      tick   = (m_samp == PER - 1);
      m_samp = (m_samp + 1) % PER;
      ns     = (m_sel + int'(pulse[0])) % 4;
      nf     = m_fr ^ pulse[1];
      load   = tick || (ns != m_sel) || (m_fr && !nf);
      if (load && !nf) begin
        v     = src_of(ns);
        m_num = (v > 8191) ? 8191 : int'(v);
        m_ovf = (v > 8191);
      end
      m_sel = ns;
      m_fr  = nf;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_num", 32'(Num), m_num);
      chk("model_sel", 32'(sel), m_sel);
      chk("model_frozen", 32'(frozen), 32'(m_fr));
      chk("model_ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic hold_btns(input bit n, input bit f, input int hi, input int lo);
    @(negedge clk);
    btn_next   = n;
    btn_freeze = f;
    repeat (hi) @(negedge clk);
    btn_next   = 0;
    btn_freeze = 0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input int e_sel, input bit e_fr,
                         input int e_num, input bit e_ovf);
    chk({nm, "_sel"}, 32'(sel), e_sel);
    chk({nm, "_frozen"}, 32'(frozen), 32'(e_fr));
    chk({nm, "_num"}, 32'(Num), e_num);
    chk({nm, "_ovf"}, 32'(ovf), 32'(e_ovf));
  endtask

  typedef struct {
    bit nxt;
    bit frz;
    int e_sel;
    bit e_fr;
    int e_num;
    bit e_ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 0, 1, 0, 8191, 1};
    tbl[1] = '{1, 0, 2, 0, 8191, 0};
    tbl[2] = '{1, 0, 3, 0, 8191, 1};
    tbl[3] = '{1, 0, 0, 0, 1234, 0};
    tbl[4] = '{0, 1, 0, 1, 1234, 0};
    tbl[5] = '{1, 0, 1, 1, 1234, 0};
    tbl[6] = '{1, 1, 2, 0, 8191, 0};
    tbl[7] = '{1, 1, 3, 1, 8191, 0};
    tbl[8] = '{0, 1, 3, 0, 8191, 1};
    tbl[9] = '{1, 0, 0, 0, 1234, 0};

    rst = 1; btn_next = 0; btn_freeze = 0;
    src0 = 1234; src1 = 40000; src2 = 8191; src3 = 8192;
    repeat (3) @(negedge clk);
    chk_out("reset", 0, 0, 0, 0);
    chk_en = 1;
    rst = 0;

    repeat (15) @(negedge clk);
    chk("pre_tick_num", 32'(Num), 0);
    @(negedge clk);
    chk("first_tick_num", 32'(Num), 1234);
    chk("first_tick_sel", 32'(sel), 0);

    for (int i = 0; i < 10; i++) begin
      hold_btns(tbl[i].nxt, tbl[i].frz, 10, 10);
      chk_out($sformatf("vec%0d", i), tbl[i].e_sel, tbl[i].e_fr, tbl[i].e_num, tbl[i].e_ovf);
    end

    hold_btns(1, 0, 2, 20);
    chk("glitch_sel", 32'(sel), 0);
    chk("glitch_num", 32'(Num), 1234);

    hold_btns(0, 1, 10, 10);
    chk_out("freeze_on", 0, 1, 1234, 0);
    src0 = 777;
    repeat (3 * PER) @(negedge clk);
    chk("frozen_hold_num", 32'(Num), 1234);
    hold_btns(1, 0, 10, 10);
    chk_out("frozen_next", 1, 1, 1234, 0);
    hold_btns(0, 1, 10, 10);
    chk_out("unfreeze", 1, 0, 8191, 1);

    hold_btns(1, 0, 10, 10);
    hold_btns(0, 1, 10, 10);
    chk_out("pre_rst", 2, 1, 8191, 0);
    @(negedge clk);
    btn_next = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    btn_next = 0;
    @(negedge clk);
    rst = 0;
    chk_out("mid_rst", 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    chk("post_rst_sel", 32'(sel), 0);
    chk("post_rst_frozen", 32'(frozen), 0);

    for (int k = 0; k < 400; k++) begin
      btn_next   = ($urandom_range(0, 2) == 0);
      btn_freeze = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: src0 = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 9000) : $urandom;
        1: src1 = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 9000) : $urandom;
        2: src2 = ($urandom_range(0, 1) != 0) ? $urandom_range(8190, 8193) : $urandom;
        default: src3 = $urandom_range(0, 9000);
      endcase
      rst = ($urandom_range(0, 60) == 0);
      @(negedge clk);
      rst = 0;
      repeat ($urandom_range(0, 9)) @(negedge clk);
    end

    btn_next = 0;
    btn_freeze = 0;
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
